// File: rtl/cordic_pkg.sv
// Shared Q2.30 type, CORDIC constants and float<->fixed conversion helpers for cordic_cos_fp.
// The optional range check (macro CORDIC_RANGE_CHECK_EN) lives in the top module.
package cordic_pkg;

   typedef logic signed [31:0] q2_30_t;

   localparam logic [31:0] CORDIC_K  = 32'h26DD3B6A;
   localparam logic [31:0] FP_QNAN   = 32'h7FC00000;
   localparam logic [31:0] FP_ONE    = 32'h3F800000;
   localparam logic [31:0] FP_CLAMP  = 32'h3FC00000;
   localparam logic [31:0] FIX_CLAMP = 32'h60000000;

   // atan(2^-i) in Q2.30, i = 0..31
   localparam logic [31:0] ATAN_ROM [32] = '{
      32'h3243F6A8, 32'h1DAC6705, 32'h0FADBAFC, 32'h07F56EA6,
      32'h03FEAB76, 32'h01FFD55B, 32'h00FFFAAA, 32'h007FFF55,
      32'h003FFFEA, 32'h001FFFFD, 32'h000FFFFF, 32'h0007FFFF,
      32'h0003FFFF, 32'h0001FFFF, 32'h0000FFFF, 32'h00007FFF,
      32'h00003FFF, 32'h00001FFF, 32'h00000FFF, 32'h000007FF,
      32'h000003FF, 32'h000001FF, 32'h000000FF, 32'h0000007F,
      32'h0000003F, 32'h0000001F, 32'h0000000F, 32'h00000008,
      32'h00000004, 32'h00000002, 32'h00000001, 32'h00000000
   };

   // NaN and Inf have an all-ones exponent, so a magnitude compare catches them too.
   function automatic logic float_out_of_range(input logic [31:0] f);
      return f[30:0] > FP_CLAMP[30:0];
   endfunction

   function automatic logic [31:0] float_to_fixed(input logic [31:0] f);
      logic [7:0]  e;
      logic [31:0] mant;
      logic [31:0] mag;
      e    = f[30:23];
      mant = {8'h00, 1'b1, f[22:0]};
      mag  = '0;
      if (float_out_of_range(f)) begin
         mag = FIX_CLAMP;
      end else if (e >= 8'd120) begin
         mag = mant << (e - 8'd120);
      end else if (e >= 8'd97) begin
         mag = mant >> (8'd120 - e);
      end
      return mag;
   endfunction

   function automatic logic [31:0] fixed_to_float(input q2_30_t x);
      logic [4:0]  lead;
      logic [31:0] norm;
      logic [31:0] f;
      lead = '0;
      for (int b = 0; b < 31; b++) begin
         if (x[b]) lead = 5'(b);
      end
      norm = x << (5'd31 - lead);
      f    = '0;
      if (x > 0) f = {1'b0, {3'b000, lead} + 8'd97, norm[30:8]};
      return f;
   endfunction

endpackage

// File: rtl/cordic_iter.sv
// One combinational rotation-mode CORDIC micro-rotation at shift index `shift`.
module cordic_iter
   import cordic_pkg::*;
(
   input  q2_30_t     x,
   input  q2_30_t     y,
   input  q2_30_t     z,
   input  logic [4:0] shift,
   output q2_30_t     x_next,
   output q2_30_t     y_next,
   output q2_30_t     z_next
);

   q2_30_t x_shr;
   q2_30_t y_shr;
   q2_30_t atan_i;

   assign x_shr  = x >>> shift;
   assign y_shr  = y >>> shift;
   assign atan_i = q2_30_t'(ATAN_ROM[shift]);

   always_comb begin
      if (z >= 0) begin
         x_next = x - y_shr;
         y_next = y + x_shr;
         z_next = z - atan_i;
      end else begin
         x_next = x + y_shr;
         y_next = y - x_shr;
         z_next = z + atan_i;
      end
   end

endmodule

// File: rtl/cordic_cos_fp.sv
// Pipelined float32 cosine: float->Q2.30 entry, CORDIC rotation stages, Q2.30->float exit.
// Define CORDIC_RANGE_CHECK_EN to return quiet NaN for NaN/Inf/|x| > 1.5 instead of clamping.
module cordic_cos_fp
   import cordic_pkg::*;
#(
   parameter int unsigned ITERATIONS      = 14,
   parameter int unsigned ITERS_PER_STAGE = 2
) (
   input  logic        clock,
   input  logic        aclr,
   input  logic        clk_en,
   input  logic        start,
   input  logic [31:0] dataa,
   output logic [31:0] result,
   output logic        done
);

   localparam int unsigned STAGES  = ITERATIONS / ITERS_PER_STAGE;
   localparam int unsigned LATENCY = 2 + STAGES;

   q2_30_t            x_q [STAGES+1];
   q2_30_t            y_q [STAGES+1];
   q2_30_t            z_q [STAGES+1];
   q2_30_t            x_d [1:STAGES];
   q2_30_t            y_d [1:STAGES];
   q2_30_t            z_d [1:STAGES];
   logic [LATENCY-1:0] valid_q;
   logic [31:0]       result_q;
   logic [31:0]       result_d;
   q2_30_t            z_init;

   assign z_init = dataa[31] ? -q2_30_t'(float_to_fixed(dataa)) : q2_30_t'(float_to_fixed(dataa));

   for (genvar s = 1; s <= STAGES; s++) begin : g_stage
      q2_30_t xc [ITERS_PER_STAGE+1];
      q2_30_t yc [ITERS_PER_STAGE+1];
      q2_30_t zc [ITERS_PER_STAGE+1];

      assign xc[0] = x_q[s-1];
      assign yc[0] = y_q[s-1];
      assign zc[0] = z_q[s-1];

      for (genvar k = 0; k < ITERS_PER_STAGE; k++) begin : g_iter
         localparam int unsigned SHIFT = (s - 1) * ITERS_PER_STAGE + k;
         cordic_iter u_iter (
            .x      (xc[k]),
            .y      (yc[k]),
            .z      (zc[k]),
            .shift  (5'(SHIFT)),
            .x_next (xc[k+1]),
            .y_next (yc[k+1]),
            .z_next (zc[k+1])
         );
      end

      assign x_d[s] = xc[ITERS_PER_STAGE];
      assign y_d[s] = yc[ITERS_PER_STAGE];
      assign z_d[s] = zc[ITERS_PER_STAGE];
   end

`ifdef CORDIC_RANGE_CHECK_EN
   logic [STAGES:0] oor_q;

   always_ff @(posedge clock or negedge aclr) begin
      if (!aclr) begin
         oor_q <= '0;
      end else if (clk_en) begin
         oor_q <= {oor_q[STAGES-1:0], float_out_of_range(dataa)};
      end
   end

   assign result_d = oor_q[STAGES] ? FP_QNAN : fixed_to_float(x_q[STAGES]);
`else
   assign result_d = fixed_to_float(x_q[STAGES]);
`endif

   always_ff @(posedge clock or negedge aclr) begin
      if (!aclr) begin
         for (int s = 0; s <= STAGES; s++) begin
            x_q[s] <= '0;
            y_q[s] <= '0;
            z_q[s] <= '0;
         end
         valid_q  <= '0;
         result_q <= '0;
      end else if (clk_en) begin
         x_q[0] <= q2_30_t'(CORDIC_K);
         y_q[0] <= '0;
         z_q[0] <= z_init;
         for (int s = 1; s <= STAGES; s++) begin
            x_q[s] <= x_d[s];
            y_q[s] <= y_d[s];
            z_q[s] <= z_d[s];
         end
         valid_q <= {valid_q[LATENCY-2:0], start};
         // Only qualifying outputs update result, so it stays 0 until the first done.
         if (valid_q[LATENCY-2]) result_q <= result_d;
      end
   end

   assign result = result_q;
   assign done   = valid_q[LATENCY-1];

endmodule

// File: tb/tb_cordic_cos_fp.sv
// Self-checking bench for cordic_cos_fp: vector table, streaming, clock-enable hold, reset, random.
module tb_cordic_cos_fp;
   import cordic_pkg::*;

`ifdef CORDIC_RANGE_CHECK_EN
   localparam logic RC = 1'b1;
`else
   localparam logic RC = 1'b0;
`endif

   typedef struct {
      real  v;
      logic nan;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      real         v;
      logic        nan;
   } vec_t;

   logic        clock = 1'b0;
   logic        aclr;
   logic        clk_en;
   logic        start;
   logic [31:0] dataa;
   logic [31:0] result;
   logic        done;

   int    errors = 0;
   int    checks = 0;
   int    cyc = 0;
   int    n_done = 0;
   int    first_done = -1;
   int    last_done = -1;
   string phase = "init";
   exp_t  sb[$];

   cordic_cos_fp dut (
      .clock  (clock),
      .aclr   (aclr),
      .clk_en (clk_en),
      .start  (start),
      .dataa  (dataa),
      .result (result),
      .done   (done)
   );

   always #5 clock = ~clock;

   function automatic real f2r(input logic [31:0] f);
      real m;
      int  e;
      e = int'(f[30:23]);
      if (e == 0) return 0.0;
      m = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (e - 127));
      return f[31] ? -m : m;
   endfunction

   function automatic logic [31:0] r2f(input real v);
      real         a;
      int          e;
      logic [22:0] m;
      if (v == 0.0) return 32'h0;
      a = (v < 0.0) ? -v : v;
      e = 0;
      while (a >= 2.0) begin a = a / 2.0; e++; end
      while (a < 1.0) begin a = a * 2.0; e--; end
      m = 23'($rtoi((a - 1.0) * 8388608.0));
      return {(v < 0.0) ? 1'b1 : 1'b0, 8'(e + 127), m};
   endfunction

   // Reference: cosine of the clamped magnitude; tiny inputs flush to zero.
   function automatic exp_t model(input logic [31:0] f);
      exp_t r;
      real  mag;
      logic big;
      if (f[30:23] == 8'hFF) mag = 10.0;
      else if (f[30:23] < 8'd97) mag = 0.0;
      else mag = f2r({1'b0, f[30:0]});
      big = mag > 1.5;
      r.nan = RC & big;
      if (big) mag = 1.5;
      r.v = $cos(mag);
      return r;
   endfunction

   task automatic check_int(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, got, want);
      end
   endtask

   task automatic check_bits(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, got, want);
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input exp_t e);
      real d;
      checks++;
      if (e.nan) begin
         if (got !== FP_QNAN) begin
            errors++;
            $display("FAIL %s: result=%h required %h", name, got, FP_QNAN);
         end
      end else begin
         d = f2r(got) - e.v;
         if (d < 0.0) d = -d;
         if ($isunknown(got) || got[31] || got[30:23] == 8'hFF || d > 2.5e-4) begin
            errors++;
            $display("FAIL %s: result=%h (%f) required %f +/- 2.5e-4", name, got, f2r(got), e.v);
         end
      end
   endtask

   // One clock: drive, wait for the edge, then retire any output and record a capture.
   task automatic step(input logic st, input logic en, input logic [31:0] a, input exp_t e);
      exp_t h;
      start  = st;
      clk_en = en;
      dataa  = a;
      @(posedge clock);
      #1;
      cyc++;
      if (en && done) begin
         n_done++;
         if (first_done < 0) first_done = cyc;
         last_done = cyc;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_unexpected_done: done=1 required 0", phase);
         end else begin
            h = sb.pop_front();
            check_val(phase, result, h);
         end
      end
      if (st && en) sb.push_back(e);
   endtask

   initial begin
      vec_t        tbl[14];
      exp_t        ex;
      exp_t        idle;
      int          lat;
      int          d0;
      int          c0;
      logic [31:0] a;
      logic        st;
      logic        en;

      idle.v   = 1.0;
      idle.nan = 1'b0;
      tbl[0]  = '{32'h00000000, 1.0,      1'b0};
      tbl[1]  = '{32'h80000000, 1.0,      1'b0};
      tbl[2]  = '{32'h3F800000, 0.540302, 1'b0};
      tbl[3]  = '{32'hBF800000, 0.540302, 1'b0};
      tbl[4]  = '{32'hBF000000, 0.877583, 1'b0};
      tbl[5]  = '{32'h3F000000, 0.877583, 1'b0};
      tbl[6]  = '{32'h3E800000, 0.968912, 1'b0};
      tbl[7]  = '{32'hBF400000, 0.731689, 1'b0};
      tbl[8]  = '{32'h3FC00000, 0.070737, 1'b0};
      tbl[9]  = '{32'h00000001, 1.0,      1'b0};
      tbl[10] = '{32'h32000000, 1.0,      1'b0};
      tbl[11] = '{32'h40000000, 0.070737, RC};
      tbl[12] = '{32'h7FC00000, 0.070737, RC};
      tbl[13] = '{32'hFF800000, 0.070737, RC};

      aclr   = 1'b0;
      start  = 1'b0;
      clk_en = 1'b0;
      dataa  = 32'h0;
      repeat (3) @(posedge clock);
      #1;
      check_bits("reset_result", result, 32'h0);
      check_int("reset_done", int'(done), 0);
      aclr = 1'b1;

      for (int i = 0; i < 14; i++) begin
         phase  = $sformatf("table%0d", i);
         d0     = n_done;
         ex.v   = tbl[i].v;
         ex.nan = tbl[i].nan;
         step(1'b1, 1'b1, tbl[i].a, ex);
         lat = 1;
         while (n_done == d0 && lat < 30) begin
            step(1'b0, 1'b1, 32'h0, idle);
            lat++;
         end
         check_int({phase, "_latency"}, lat, 9);
      end

      phase      = "stream";
      d0         = n_done;
      c0         = cyc;
      first_done = -1;
      for (int k = 0; k < 16; k++) begin
         a = r2f(-1.0 + 0.125 * k);
         step(1'b1, 1'b1, a, model(a));
      end
      lat = 0;
      while (n_done - d0 < 16 && lat < 30) begin
         step(1'b0, 1'b1, 32'h0, idle);
         lat++;
      end
      check_int("stream_count", n_done - d0, 16);
      check_int("stream_consecutive", last_done - first_done, 15);
      check_int("stream_first_latency", first_done - c0, 9);

      phase = "hold_mid";
      d0    = n_done;
      step(1'b1, 1'b1, 32'hBF000000, model(32'hBF000000));
      lat = 1;
      repeat (3) begin
         step(1'b0, 1'b1, 32'h0, idle);
         lat++;
      end
      repeat (3) begin
         step(1'b1, 1'b0, 32'h3F800000, idle);
         lat++;
         check_int("hold_mid_done", int'(done), 0);
      end
      while (n_done == d0 && lat < 40) begin
         step(1'b0, 1'b1, 32'h0, idle);
         lat++;
      end
      check_int("hold_mid_latency", lat, 12);

      phase = "hold_done";
      d0    = n_done;
      ex    = model(FP_ONE);
      step(1'b1, 1'b1, FP_ONE, ex);
      lat = 1;
      while (n_done == d0 && lat < 30) begin
         step(1'b0, 1'b1, 32'h0, idle);
         lat++;
      end
      repeat (3) begin
         step(1'b1, 1'b0, 32'h3E800000, idle);
         check_int("hold_done_done", int'(done), 1);
         check_val("hold_done_result", result, ex);
      end
      step(1'b0, 1'b1, 32'h0, idle);
      check_int("hold_done_release", int'(done), 0);
      d0 = n_done;
      repeat (12) step(1'b0, 1'b1, 32'h0, idle);
      check_int("hold_no_capture", n_done - d0, 0);

      phase = "reset_midflight";
      for (int k = 0; k < 4; k++) begin
         a = r2f(0.25 * k);
         step(1'b1, 1'b1, a, model(a));
      end
      start = 1'b0;
      @(negedge clock);
      aclr = 1'b0;
      #1;
      check_int("midreset_done", int'(done), 0);
      check_bits("midreset_result", result, 32'h0);
      sb.delete();
      @(posedge clock);
      #1;
      aclr = 1'b1;
      d0   = n_done;
      repeat (12) step(1'b0, 1'b1, 32'h0, idle);
      check_int("no_stale_done", n_done - d0, 0);
      check_bits("result_after_reset", result, 32'h0);

      phase = "random";
      for (int n = 0; n < 400; n++) begin
         st = ($urandom % 4) != 0;
         en = ($urandom % 5) != 0;
         if (($urandom % 8) == 0) a = $urandom;
         else a = {1'($urandom), 8'($urandom_range(96, 127)), 23'($urandom)};
         step(st, en, a, model(a));
      end
      lat = 0;
      while (sb.size() != 0 && lat < 40) begin
         step(1'b0, 1'b1, 32'h0, idle);
         lat++;
      end
      check_int("random_drain", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
